// File: rtl/vga_mon_pkg.sv
// Shared types and constants for the VGA frame monitor: FSM states, err bit
// positions, signature width and the per-cycle signature fold.
package vga_mon_pkg;

  typedef enum logic {
    S_SEEK  = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  localparam int unsigned ERR_HPERIOD = 0;
  localparam int unsigned ERR_HWIDTH  = 1;
  localparam int unsigned ERR_VLINES  = 2;
  localparam int unsigned ERR_VWIDTH  = 3;

  localparam int unsigned SIG_W = 32;

  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                input logic [SIG_W-1:0] pix);
    return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ pix;
  endfunction

endpackage

// File: rtl/sync_pulse_meter.sv
// Measures one sync signal: assert/deassert edges, clocks since the last
// assert edge (period) and clocks spent at the active level (width).
module sync_pulse_meter #(
  parameter logic        POL = 1'b1,
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sync,
  output logic         assert_edge,
  output logic         deassert_edge,
  output logic [W-1:0] period,
  output logic [W-1:0] width
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= ~POL;
    else     prev <= sync;
  end

  assign assert_edge   = (sync == POL) && (prev != POL);
  assign deassert_edge = (sync != POL) && (prev == POL);

  // period reads k in the k-th clock after an assert edge, saturating at MAX
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  period <= '0;
    else if (assert_edge)     period <= W'(1);
    else if (period != MAX_V) period <= period + 1'b1;
  end

  // width holds the active-cycle count through the deassert cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   width <= '0;
    else if (assert_edge)                      width <= W'(1);
    else if ((sync == POL) && (width != MAX_V)) width <= width + 1'b1;
  end

endmodule

// File: rtl/vga_frame_monitor.sv
// VGA stream monitor: checks hs/vs timing, folds pixels into a per-frame
// signature and reports lock. Define FRAME_MON_WINDOW_EN to restrict the
// signature to the WIN_X0..WIN_X1 / WIN_Y0..WIN_Y1 pixel window.
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter int unsigned H_TOTAL     = 1344,
  parameter int unsigned V_TOTAL     = 806,
  parameter int unsigned H_SYNC_W    = 136,
  parameter int unsigned V_SYNC_W    = 6,
  parameter logic        SYNC_POL    = 1'b1,
  parameter int unsigned COLOR_W     = 4,
  parameter int unsigned LOCK_FRAMES = 2
`ifdef FRAME_MON_WINDOW_EN
  ,
  parameter int unsigned WIN_X0      = 0,
  parameter int unsigned WIN_X1      = H_TOTAL - 1,
  parameter int unsigned WIN_Y0      = 0,
  parameter int unsigned WIN_Y1      = V_TOTAL - 1
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hs,
  input  logic                          vs,
  input  logic [COLOR_W-1:0]            r,
  input  logic [COLOR_W-1:0]            g,
  input  logic [COLOR_W-1:0]            b,
  input  logic                          clr_err,
  output logic                          frame_done,
  output logic [SIG_W-1:0]              frame_sig,
  output logic [$clog2(V_TOTAL+2)-1:0]  frame_lines,
  output logic [15:0]                   frame_cnt,
  output logic                          locked,
  output logic [3:0]                    err
);

  localparam int unsigned HW     = $clog2(H_TOTAL + 2);
  localparam int unsigned VW_MAX = V_SYNC_W * H_TOTAL;
  localparam int unsigned VW     = $clog2(VW_MAX + 2);
  localparam int unsigned LW     = $clog2(V_TOTAL + 2);
  localparam int unsigned GW     = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0] H_TOTAL_V = HW'(H_TOTAL);
  localparam logic [HW-1:0] H_SYNC_V  = HW'(H_SYNC_W);
  localparam logic [VW-1:0] V_WIDTH_V = VW'(VW_MAX);
  localparam logic [LW-1:0] V_TOTAL_V = LW'(V_TOTAL);
  localparam logic [LW-1:0] LINES_MAX = LW'(V_TOTAL + 1);
  localparam logic [GW-1:0] LOCK_V    = GW'(LOCK_FRAMES);

  state_t state_q, state_d;

  logic          hs_rise, hs_fall, vs_rise, vs_fall;
  logic [HW-1:0] hs_period, hs_width;
  logic [VW-1:0] vs_width, vs_period_unused;

  logic             in_frame, frame_close;
  logic             h_armed;
  logic [LW-1:0]    lines_q, lines_d;
  logic [SIG_W-1:0] sig_q, pix;
  logic             pix_en;
  logic [3:0]       err_set;
  logic             frame_bad_q, frame_bad;
  logic [GW-1:0]    good_q, good_next;

  sync_pulse_meter #(
    .POL (SYNC_POL),
    .W   (HW),
    .MAX (H_TOTAL + 1)
  ) u_hs_meter (
    .clk           (clk),
    .rst           (rst),
    .sync          (hs),
    .assert_edge   (hs_rise),
    .deassert_edge (hs_fall),
    .period        (hs_period),
    .width         (hs_width)
  );

  sync_pulse_meter #(
    .POL (SYNC_POL),
    .W   (VW),
    .MAX (VW_MAX + 1)
  ) u_vs_meter (
    .clk           (clk),
    .rst           (rst),
    .sync          (vs),
    .assert_edge   (vs_rise),
    .deassert_edge (vs_fall),
    .period        (vs_period_unused),
    .width         (vs_width)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_SEEK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEEK:  if (vs_rise) state_d = S_FRAME;
      S_FRAME: state_d = S_FRAME;
      default: state_d = S_SEEK;
    endcase
  end

  always_comb begin
    in_frame    = (state_q == S_FRAME);
    frame_close = in_frame && vs_rise;
  end

  // An hs edge coinciding with the vs edge opens line 1 of the new frame.
  always_comb begin
    if (vs_rise)
      lines_d = hs_rise ? LW'(1) : '0;
    else if (hs_rise && (lines_q != LINES_MAX))
      lines_d = lines_q + 1'b1;
    else
      lines_d = lines_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lines_q <= '0;
    else     lines_q <= lines_d;
  end

  // The first hs edge after leaving S_SEEK has no trustworthy period behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    h_armed <= 1'b0;
    else if (!in_frame)         h_armed <= 1'b0;
    else if (hs_rise)           h_armed <= 1'b1;
  end

  always_comb begin
    err_set = '0;
    if (in_frame) begin
      err_set[ERR_HPERIOD] = h_armed &&
                             (hs_rise ? (hs_period != H_TOTAL_V) : (hs_period == H_TOTAL_V));
      err_set[ERR_HWIDTH]  = hs_fall && (hs_width != H_SYNC_V);
      err_set[ERR_VLINES]  = vs_rise && (lines_q != V_TOTAL_V);
      err_set[ERR_VWIDTH]  = vs_fall && (vs_width != V_WIDTH_V);
    end
  end

  assign pix = SIG_W'({r, g, b});

`ifdef FRAME_MON_WINDOW_EN
  logic [HW-1:0] x_pos;
  logic [LW-1:0] y_pos;

  always_comb begin
    x_pos = hs_rise ? '0 : hs_period;
    y_pos = (lines_d == '0) ? '0 : lines_d - 1'b1;
  end

  assign pix_en = (32'(x_pos) >= WIN_X0) && (32'(x_pos) <= WIN_X1) &&
                  (32'(y_pos) >= WIN_Y0) && (32'(y_pos) <= WIN_Y1);
`else
  assign pix_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       sig_q <= '0;
    else if (vs_rise)              sig_q <= pix_en ? sig_step('0, pix) : '0;
    else if (in_frame && pix_en)   sig_q <= sig_step(sig_q, pix);
  end

  // Errors raised in the vs edge cycle are charged to the frame being closed.
  always_comb begin
    frame_bad = frame_bad_q || (|err_set);
    good_next = (good_q == LOCK_V) ? good_q : good_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_bad_q <= 1'b0;
      good_q      <= '0;
      frame_done  <= 1'b0;
      frame_sig   <= '0;
      frame_lines <= '0;
      frame_cnt   <= '0;
      locked      <= 1'b0;
      err         <= '0;
    end else begin
      frame_done <= frame_close;
      err        <= (clr_err ? 4'b0000 : err) | err_set;
      if (vs_rise)       frame_bad_q <= 1'b0;
      else if (|err_set) frame_bad_q <= 1'b1;
      if (frame_close) begin
        frame_sig   <= sig_q;
        frame_lines <= lines_q;
        frame_cnt   <= frame_cnt + 16'd1;
        if (frame_bad) begin
          good_q <= '0;
          locked <= 1'b0;
        end else begin
          good_q <= good_next;
          locked <= (good_next == LOCK_V);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor with a small 16x8 test mode.
module tb_vga_frame_monitor;

  localparam int unsigned H_TOTAL     = 16;
  localparam int unsigned V_TOTAL     = 8;
  localparam int unsigned H_SYNC_W    = 2;
  localparam int unsigned V_SYNC_W    = 1;
  localparam int unsigned COLOR_W     = 4;
  localparam int unsigned LOCK_FRAMES = 2;
  localparam int unsigned LW          = $clog2(V_TOTAL + 2);
  localparam int unsigned NONE        = 99;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               hs = 1'b0;
  logic               vs = 1'b0;
  logic               clr_err = 1'b0;
  logic [COLOR_W-1:0] r = '0;
  logic [COLOR_W-1:0] g = '0;
  logic [COLOR_W-1:0] b = '0;
  logic               frame_done;
  logic [31:0]        frame_sig;
  logic [LW-1:0]      frame_lines;
  logic [15:0]        frame_cnt;
  logic               locked;
  logic [3:0]         err;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned err0_rise_cyc = 0;
  int unsigned mark_cyc = 0;
  logic        err0_prev = 1'b0;

  vga_frame_monitor #(
    .H_TOTAL     (H_TOTAL),
    .V_TOTAL     (V_TOTAL),
    .H_SYNC_W    (H_SYNC_W),
    .V_SYNC_W    (V_SYNC_W),
    .SYNC_POL    (1'b1),
    .COLOR_W     (COLOR_W),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hs          (hs),
    .vs          (vs),
    .r           (r),
    .g           (g),
    .b           (b),
    .clr_err     (clr_err),
    .frame_done  (frame_done),
    .frame_sig   (frame_sig),
    .frame_lines (frame_lines),
    .frame_cnt   (frame_cnt),
    .locked      (locked),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic h, input logic v, input logic [11:0] pix, input logic clr);
    hs = h;
    vs = v;
    {r, g, b} = pix;
    clr_err = clr;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_done) done_cnt++;
    if (err[0] && !err0_prev) err0_rise_cyc = cyc;
    err0_prev = err[0];
  endtask

  task automatic line(input int unsigned len, input int unsigned hw, input logic v,
                      input logic [11:0] pix0, input logic clr0);
    for (int unsigned i = 0; i < len; i++)
      step(i < hw, v, (i == 0) ? pix0 : 12'h000, (i == 0) ? clr0 : 1'b0);
  endtask

  task automatic frame(input logic [11:0] pix0, input int unsigned bad_line,
                       input int unsigned bad_len, input int unsigned bad_hw,
                       input int unsigned vs_lines, input int unsigned clr_line);
    for (int unsigned l = 0; l < V_TOTAL; l++) begin
      if (l == bad_line) mark_cyc = cyc + 1;
      line((l == bad_line) ? bad_len : H_TOTAL, (l == bad_line) ? bad_hw : H_SYNC_W,
           l < vs_lines, (l == 0) ? pix0 : 12'h000, l == clr_line);
    end
  endtask

  task automatic ideal();
    frame(12'h000, NONE, 0, 0, 1, NONE);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({frame_done, locked, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: done/locked/err=%b expected 000000", {frame_done, locked, err});
    end
    n_checks++;
    if (frame_sig !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_sig: frame_sig=%h expected 00000000", frame_sig);
    end
    n_checks++;
    if ({frame_lines, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: lines=%0d cnt=%0d expected 0 0", frame_lines, frame_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    ideal();
    n_checks++;
    if (done_cnt !== 0) begin
      n_fail++;
      $display("FAIL ideal_first_edge: frame_done pulses=%0d expected 0", done_cnt);
    end
    ideal();
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL ideal_done1: frame_done pulses=%0d expected 1", done_cnt);
    end
    n_checks++;
    if (frame_lines !== LW'(8)) begin
      n_fail++;
      $display("FAIL ideal_lines: frame_lines=%0d expected 8", frame_lines);
    end
    n_checks++;
    if (frame_sig !== 32'h0) begin
      n_fail++;
      $display("FAIL ideal_sig: frame_sig=%h expected 00000000", frame_sig);
    end
    n_checks++;
    if ({locked, frame_cnt} !== {1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL ideal_lock1: locked=%b cnt=%0d expected 0 1", locked, frame_cnt);
    end
    ideal();
    n_checks++;
    if ({done_cnt, locked, frame_cnt} !== {32'd2, 1'b1, 16'd2}) begin
      n_fail++;
      $display("FAIL ideal_lock2: pulses=%0d locked=%b cnt=%0d expected 2 1 2", done_cnt, locked, frame_cnt);
    end
    n_checks++;
    if (err !== 4'b0000) begin
      n_fail++;
      $display("FAIL ideal_err: err=%b expected 0000", err);
    end
  endtask

  task automatic test_signature();
    frame(12'h001, NONE, 0, 0, 1, NONE);
    frame(12'h100, NONE, 0, 0, 1, NONE);
    n_checks++;
    if (frame_sig !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL sig_blue_lsb: frame_sig=%h expected 80000000", frame_sig);
    end
    ideal();
    n_checks++;
    if (frame_sig !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL sig_red_lsb: frame_sig=%h expected 00000080", frame_sig);
    end
    n_checks++;
    if ({locked, frame_cnt} !== {1'b1, 16'd5}) begin
      n_fail++;
      $display("FAIL sig_lock: locked=%b cnt=%0d expected 1 5", locked, frame_cnt);
    end
  endtask

  task automatic test_hperiod();
    frame(12'h000, 3, 17, H_SYNC_W, 1, NONE);
    ideal();
    n_checks++;
    if ({locked, err} !== {1'b0, 4'b0001}) begin
      n_fail++;
      $display("FAIL hper_drop: locked=%b err=%b expected 0 0001", locked, err);
    end
    ideal();
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL hper_one_good: locked=%b expected 0", locked);
    end
    ideal();
    n_checks++;
    if ({locked, err} !== {1'b1, 4'b0001}) begin
      n_fail++;
      $display("FAIL hper_relock: locked=%b err=%b expected 1 0001", locked, err);
    end
    frame(12'h000, NONE, 0, 0, 1, 0);
    n_checks++;
    if ({locked, err} !== {1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL hper_clr: locked=%b err=%b expected 1 0000", locked, err);
    end
  endtask

  task automatic test_hs_missing();
    frame(12'h000, 3, 40, 0, 1, NONE);
    n_checks++;
    if (err0_rise_cyc !== mark_cyc) begin
      n_fail++;
      $display("FAIL hs_timeout_cycle: err0 rose at cycle %0d expected %0d", err0_rise_cyc, mark_cyc);
    end
    ideal();
    n_checks++;
    if ({err, frame_lines} !== {4'b0101, LW'(7)}) begin
      n_fail++;
      $display("FAIL hs_missing_close: err=%b lines=%0d expected 0101 7", err, frame_lines);
    end
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_missing_lock: locked=%b expected 0", locked);
    end
  endtask

  task automatic test_vwidth();
    frame(12'h000, NONE, 0, 0, 2, 2);
    n_checks++;
    if (err !== 4'b1000) begin
      n_fail++;
      $display("FAIL vwidth_clr_collide: err=%b expected 1000", err);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned base;
    line(H_TOTAL, H_SYNC_W, 1'b1, 12'h000, 1'b0);
    line(H_TOTAL, H_SYNC_W, 1'b0, 12'h000, 1'b0);
    line(8, H_SYNC_W, 1'b0, 12'h000, 1'b0);
    hs = 1'b0;
    vs = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({frame_done, locked, err, frame_sig, frame_lines, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: done=%b locked=%b err=%b sig=%h lines=%0d cnt=%0d expected all 0",
               frame_done, locked, err, frame_sig, frame_lines, frame_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    err0_prev = 1'b0;
    base = done_cnt;
    ideal();
    n_checks++;
    if (done_cnt !== base) begin
      n_fail++;
      $display("FAIL reset_mid_first_edge: pulses=%0d expected %0d", done_cnt, base);
    end
    ideal();
    n_checks++;
    if (done_cnt !== base + 1) begin
      n_fail++;
      $display("FAIL reset_mid_second_edge: pulses=%0d expected %0d", done_cnt, base + 1);
    end
    n_checks++;
    if ({frame_cnt, frame_lines, locked, err} !== {16'd1, LW'(8), 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_mid_state: cnt=%0d lines=%0d locked=%b err=%b expected 1 8 0 0000",
               frame_cnt, frame_lines, locked, err);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_signature();
    test_hperiod();
    test_hs_missing();
    test_vwidth();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
